// File: rtl/fft_frame_arbiter.sv
// rtl/fft_frame_arbiter.sv - frame-granular round-robin arbiter sharing one FFT path between two streams
//
// Grants the FFT input to ch0 or ch1 for exactly one frame of FRAME_LEN beats.
// Each grant pushes the channel into a tag queue. Result frames returning from
// the FFT/accumulator path are labelled with the tag at the queue head. The tag
// is popped after FRAME_LEN return beats.
//
// Parameters:
//   FRAME_LEN  samples per frame (power of two, 2..1024)
//   TAG_DEPTH  tag queue entries (power of two, 2..16)
//
// Ports:
//   i_clk, i_rst_n               clock, synchronous active-low reset
//   i_ch{0,1}_data/valid         channel sample streams
//   o_ch{0,1}_ready              channel ready (only the granted channel, only in XFER)
//   o_fft_data/valid, i_fft_ready  FFT input stream
//   i_res_data/valid, o_res_ready  result stream from the accumulator stage
//   o_res_data/valid/ch, i_res_ready  tagged result stream to the demux
//   o_busy                       frame in flight or tags outstanding
//
// Optional feature macro FFT_ARB_LAST_EN adds o_fft_last and o_res_last
// (end-of-frame markers for the forward and return streams).

module fft_frame_arbiter #(
    parameter int FRAME_LEN = 256,
    parameter int TAG_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_ch0_data,
    input  logic        i_ch0_valid,
    output logic        o_ch0_ready,
    input  logic [31:0] i_ch1_data,
    input  logic        i_ch1_valid,
    output logic        o_ch1_ready,
    output logic [31:0] o_fft_data,
    output logic        o_fft_valid,
    input  logic        i_fft_ready,
    input  logic [31:0] i_res_data,
    input  logic        i_res_valid,
    output logic        o_res_ready,
    output logic [31:0] o_res_data,
    output logic        o_res_valid,
    output logic        o_res_ch,
    input  logic        i_res_ready,
    output logic        o_busy
`ifdef FFT_ARB_LAST_EN
    ,
    output logic        o_fft_last,
    output logic        o_res_last
`endif
);

    localparam int CW = $clog2(FRAME_LEN);
    localparam int PW = $clog2(TAG_DEPTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);
    localparam logic [PW:0]   TAG_FULL = (PW + 1)'(TAG_DEPTH);

    typedef enum logic {
        S_IDLE,
        S_XFER
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]        in_cnt_q;
    logic [CW-1:0]        res_cnt_q;
    logic                 gnt_q;
    logic                 last_gnt_q;
    logic [TAG_DEPTH-1:0] tag_mem_q;
    logic [PW-1:0]        wr_ptr_q;
    logic [PW-1:0]        rd_ptr_q;
    logic [PW:0]          tag_cnt_q;

    logic        grant;
    logic        grant_ch;
    logic        sel_valid;
    logic [31:0] sel_data;
    logic        tag_ne;
    logic        tag_full;
    logic        fwd_beat;
    logic        res_beat;
    logic        pop;

    assign sel_valid = gnt_q ? i_ch1_valid : i_ch0_valid;
    assign sel_data  = gnt_q ? i_ch1_data  : i_ch0_data;
    assign tag_ne    = (tag_cnt_q != '0);
    assign tag_full  = (tag_cnt_q == TAG_FULL);
    assign fwd_beat  = (state_q == S_XFER) & sel_valid & i_fft_ready;
    assign res_beat  = i_res_valid & i_res_ready & tag_ne;
    assign pop       = res_beat & (res_cnt_q == LAST_IDX);

    // Return path: gated by tag availability so untagged results are held off
    // rather than accepted with an undefined channel.
    assign o_res_valid = i_res_valid & tag_ne;
    assign o_res_ready = i_res_ready & tag_ne;
    assign o_res_data  = tag_ne ? i_res_data : 32'd0;
    assign o_res_ch    = tag_ne & tag_mem_q[rd_ptr_q];
    assign o_busy      = (state_q == S_XFER) | tag_ne;

`ifdef FFT_ARB_LAST_EN
    assign o_fft_last = (state_q == S_XFER) & (in_cnt_q == LAST_IDX);
    assign o_res_last = tag_ne & (res_cnt_q == LAST_IDX);
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant       = 1'b0;
        grant_ch    = 1'b0;
        o_fft_data  = 32'd0;
        o_fft_valid = 1'b0;
        o_ch0_ready = 1'b0;
        o_ch1_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!tag_full && (i_ch0_valid || i_ch1_valid)) begin
                    grant = 1'b1;
                    // Tie goes to the channel that did not win last time;
                    // a lone candidate wins outright (ch1 iff it is valid).
                    grant_ch = (i_ch0_valid && i_ch1_valid) ? ~last_gnt_q : i_ch1_valid;
                    state_d  = S_XFER;
                end
            end
            S_XFER: begin
                o_fft_data  = sel_data;
                o_fft_valid = sel_valid;
                o_ch0_ready = ~gnt_q & i_fft_ready;
                o_ch1_ready = gnt_q & i_fft_ready;
                if (fwd_beat && (in_cnt_q == LAST_IDX)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            in_cnt_q   <= '0;
            res_cnt_q  <= '0;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            tag_mem_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tag_cnt_q  <= '0;
        end else begin
            if (grant) begin
                gnt_q               <= grant_ch;
                last_gnt_q          <= grant_ch;
                in_cnt_q            <= '0;
                tag_mem_q[wr_ptr_q] <= grant_ch;
                wr_ptr_q            <= wr_ptr_q + PW'(1);
            end else if (fwd_beat) begin
                in_cnt_q <= in_cnt_q + CW'(1);
            end

            if (res_beat) begin
                res_cnt_q <= res_cnt_q + CW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end

            case ({grant, pop})
                2'b10:   tag_cnt_q <= tag_cnt_q + (PW + 1)'(1);
                2'b01:   tag_cnt_q <= tag_cnt_q - (PW + 1)'(1);
                default: tag_cnt_q <= tag_cnt_q;
            endcase
        end
    end

endmodule
